mem_rd_arbiter: RTL



---
 rtl/mem_rd_arbiter_pkg.sv | 15 +
 rtl/mem_rd_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter_pkg.sv
// Shared encodings for the sram read-channel arbiter: FSM states, grant ids
// and the OKAY response code.
package mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic       GNT_IFU   = 1'b0;
    localparam logic       GNT_LSU   = 1'b1;
    localparam logic [2:0] RESP_OKAY = 3'b000;

endpackage

// File: rtl/mem_rd_arbiter.sv
// Arbitrates one sram read channel (ar/r) between the ifu and the lsu, with
// a single read transaction in flight at a time.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int RESP_LEN = 3,
    parameter int ARB_RR   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [DATA_LEN-1:0] ifu_raddr,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_LEN-1:0] ifu_rdata,
    output logic [RESP_LEN-1:0] ifu_rresp,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [DATA_LEN-1:0] lsu_raddr,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic [RESP_LEN-1:0] lsu_rresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [DATA_LEN-1:0] s_raddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_LEN-1:0] s_rdata,
    input  logic [RESP_LEN-1:0] s_rresp
);

    state_e state_r;
    logic   grant_r;
    logic   last_grant_r;

    // Winner when leaving IDLE; under round-robin a tie goes to whoever was not served last.
    function automatic logic pick_winner(input logic ifu_req, input logic lsu_req,
                                         input logic last_gnt);
        logic winner;
        if (ifu_req && lsu_req) begin
            if (ARB_RR != 0) begin
                winner = ~last_gnt;
            end else begin
                winner = GNT_LSU;
            end
        end else if (lsu_req) begin
            winner = GNT_LSU;
        end else begin
            winner = GNT_IFU;
        end
        return winner;
    endfunction

    // Arbitration FSM: state, current grant and the grant of the last completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= GNT_IFU;
            last_grant_r <= GNT_IFU;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ifu_arvalid || lsu_arvalid) begin
                        grant_r <= pick_winner(ifu_arvalid, lsu_arvalid, last_grant_r);
                        state_r <= ADDR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state_r <= DATA;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready) begin
                        last_grant_r <= grant_r;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= DATA;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Channel steering; IDLE drives nothing, so no arvalid reaches an arready combinationally.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        s_arvalid   = 1'b0;
        s_raddr     = '0;
        s_rready    = 1'b0;
        case (state_r)
            ADDR: begin
                if (grant_r == GNT_LSU) begin
                    s_arvalid   = lsu_arvalid;
                    s_raddr     = lsu_raddr;
                    lsu_arready = s_arready;
                end else begin
                    s_arvalid   = ifu_arvalid;
                    s_raddr     = ifu_raddr;
                    ifu_arready = s_arready;
                end
            end
            DATA: begin
                if (grant_r == GNT_LSU) begin
                    s_rready   = lsu_rready;
                    lsu_rvalid = s_rvalid;
                    lsu_rdata  = s_rdata;
                    lsu_rresp  = s_rresp;
                end else begin
                    s_rready   = ifu_rready;
                    ifu_rvalid = s_rvalid;
                    ifu_rdata  = s_rdata;
                    ifu_rresp  = s_rresp;
                end
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

endmodule
